// File: rtl/systolic_drain_fp16_pkg.sv
// Shared FP16 field definitions and drain FSM state encoding for the systolic drain stage.
package systolic_drain_fp16_pkg;

  localparam int unsigned FP16_SIGN_W   = 1;
  localparam int unsigned FP16_EXP_W    = 5;
  localparam int unsigned FP16_MANT_W   = 10;
  localparam int unsigned FP16_W        = FP16_SIGN_W + FP16_EXP_W + FP16_MANT_W;
  localparam int unsigned EXP_BIAS      = 15;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StHold
  } state_t;

endpackage

// File: rtl/systolic_drain_fp16_acc2fp16.sv
// Combinational fixed-point accumulator to FP16 converter: leading-one detect, RNE, saturation.
module acc2fp16
  import systolic_drain_fp16_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned IN_BIAS   = 15
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [FP16_EXP_W-1:0] exp,
  output logic [FP16_W-1:0]     fp16
);

  localparam int unsigned PW = $clog2(ACC_WIDTH);

  logic                   s;
  logic [ACC_WIDTH-1:0]   m;
  logic [ACC_WIDTH-1:0]   norm;
  logic [PW-1:0]          p;
  logic [FP16_MANT_W-1:0] mant;
  logic [FP16_MANT_W:0]   mant_r;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic signed [9:0]      e_raw;
  logic signed [9:0]      e_fin;

  always_comb begin
    s = acc[ACC_WIDTH-1];
    m = s ? (~acc + 1'b1) : acc;
    p = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (m[i]) p = PW'(i);
    end
    // Left-justify the leading one so the mantissa/guard/sticky taps are fixed.
    norm   = m << (PW'(ACC_WIDTH - 1) - p);
    mant   = norm[ACC_WIDTH-2 -: FP16_MANT_W];
    guard  = norm[ACC_WIDTH-2-FP16_MANT_W];
    sticky = |norm[ACC_WIDTH-3-FP16_MANT_W:0];
    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + (FP16_MANT_W+1)'(inc);
    // Rebias from the input exponent domain into the FP16 exponent domain.
    e_raw  = 10'(exp) - 10'(IN_BIAS) + 10'(EXP_BIAS) + 10'(p) - 10'(FRAC_BITS);
    e_fin  = mant_r[FP16_MANT_W] ? e_raw + 10'sd1 : e_raw;

    if (m == '0) begin
      fp16 = '0;
    end else if (e_fin >= 10'sd31) begin
      fp16 = s ? FP16_NEG_INF : FP16_POS_INF;
    end else if (e_fin <= 10'sd0) begin
      fp16 = {s, 15'h0};
    end else begin
      fp16 = {s, e_fin[FP16_EXP_W-1:0], mant_r[FP16_MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/systolic_drain_fp16.sv
// Snapshots the PE accumulators on done rising and streams them out as FP16 in row-major order.
module systolic_drain_fp16
  import systolic_drain_fp16_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned N         = 2,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned EXP_BIAS  = 15,
  localparam int unsigned NE       = N * N,
  localparam int unsigned IW       = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done,
  input  logic [NE*ACC_WIDTH-1:0]       acc_in,
  input  logic [NE*FP16_EXP_W-1:0]      exp_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FP16_W-1:0]             out_data,
  output logic [IW-1:0]                 out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun
);

  state_t                   state;
  logic                     done_q;
  logic                     rise;
  logic [IW-1:0]            k;
  logic [NE*ACC_WIDTH-1:0]  acc_snap;
  logic [NE*FP16_EXP_W-1:0] exp_snap;
  logic [ACC_WIDTH-1:0]     acc_sel;
  logic [FP16_EXP_W-1:0]    exp_sel;
  logic [FP16_W-1:0]        fp16;

  assign rise = done & ~done_q;

  always_comb begin
    acc_sel = '0;
    exp_sel = '0;
    for (int i = 0; i < NE; i++) begin
      if (k == IW'(i)) begin
        acc_sel = acc_snap[i*ACC_WIDTH +: ACC_WIDTH];
        exp_sel = exp_snap[i*FP16_EXP_W +: FP16_EXP_W];
      end
    end
  end

  acc2fp16 #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .IN_BIAS   (EXP_BIAS)
  ) u_conv (
    .acc  (acc_sel),
    .exp  (exp_sel),
    .fp16 (fp16)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      done_q    <= 1'b0;
      k         <= '0;
      acc_snap  <= '0;
      exp_snap  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_q <= done;
      // busy is still high in the cycle the last element is accepted, so that rise is dropped too.
      if (rise && busy) overrun <= 1'b1;
      unique case (state)
        StIdle: begin
          if (rise) begin
            acc_snap <= acc_in;
            exp_snap <= exp_in;
            busy     <= 1'b1;
            k        <= '0;
            state    <= StConv;
          end
        end
        StConv: begin
          out_data  <= fp16;
          out_idx   <= k;
          out_last  <= (k == IW'(NE - 1));
          out_valid <= 1'b1;
          state     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              k     <= k + 1'b1;
              state <= StConv;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain_fp16.sv
// Directed self-checking bench for systolic_drain_fp16 with N=2.
module tb_systolic_drain_fp16;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  logic [127:0]  acc_in;
  logic [19:0]   exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] main_exp [NE] = '{16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40};
  logic [15:0] rnd_exp  [NE] = '{16'h4000, 16'h4002, 16'h4400, 16'h0000};
  logic [15:0] sat_exp  [NE] = '{16'h7C00, 16'hFC00, 16'h0000, 16'hD400};

  always #5 clk = ~clk;

  systolic_drain_fp16 #(
    .ACC_WIDTH (32),
    .N         (2),
    .FRAC_BITS (10),
    .EXP_BIAS  (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_in    (acc_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic load(input logic [31:0] a0, a1, a2, a3, input logic [4:0] e0, e1, e2, e3);
    acc_in = {a3, a2, a1, a0};
    exp_in = {e3, e2, e1, e0};
  endtask

  task automatic load_main();
    load(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00, 5'd15, 5'd15, 5'd15, 5'd15);
  endtask

  // Waits (bounded) at negedges for out_valid.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; out_ready = 1'b0;
    acc_in = '0; exp_in = '0;
    #12;
    n_cmp++;
    if ({out_valid, out_data, out_idx, out_last, busy, overrun} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b d=%h i=%0d l=%b b=%b o=%b required all zero",
               out_valid, out_data, out_idx, out_last, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drain();
    bit ok;
    load_main();
    done = 1'b1;
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL drain_valid i=%0d got none required valid", i); end
      n_cmp++;
      if (out_data !== main_exp[i] || out_idx !== 2'(i) || out_last !== (i == NE - 1)
          || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL drain_elem i=%0d got d=%h idx=%0d last=%b busy=%b required d=%h idx=%0d",
                 i, out_data, out_idx, out_last, busy, main_exp[i], i);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_end got busy=%b valid=%b required 0 0", busy, out_valid);
    end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    load_main();
    done = 1'b1;
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL stall_valid i=%0d got none required valid", i); end
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== main_exp[i] || out_idx !== 2'(i)) begin
          n_bad++;
          $display("FAIL stall_hold i=%0d s=%0d got v=%b d=%h idx=%0d required v=1 d=%h idx=%0d",
                   i, s, out_valid, out_data, out_idx, main_exp[i], i);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_end got busy=%b required 0", busy); end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_convert(input string name, input logic [15:0] expv [NE]);
    bit ok;
    done = 1'b1;
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok || out_data !== expv[i] || out_idx !== 2'(i)) begin
        n_bad++;
        $display("FAIL %s i=%0d got ok=%b d=%h idx=%0d required d=%h idx=%0d",
                 name, i, ok, out_data, out_idx, expv[i], i);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    bit ok;
    int extra;
    load_main();
    done = 1'b1;
    wait_valid(ok);
    done = 1'b0;
    @(negedge clk);
    acc_in = {4{32'h12345678}};
    done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set got %b required 1", overrun); end
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok || out_data !== main_exp[i] || out_idx !== 2'(i)) begin
        n_bad++;
        $display("FAIL overrun_snap i=%0d got ok=%b d=%h idx=%0d required d=%h idx=%0d",
                 i, ok, out_data, out_idx, main_exp[i], i);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_single got extra=%0d overrun=%b required 0 1", extra, overrun);
    end
    done = 1'b0;
    load_main();
    @(negedge clk);
    done = 1'b1;
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok || out_data !== main_exp[i] || out_idx !== 2'(i) || overrun !== 1'b1) begin
        n_bad++;
        $display("FAIL overrun_redrain i=%0d got ok=%b d=%h idx=%0d ov=%b required d=%h idx=%0d ov=1",
                 i, ok, out_data, out_idx, overrun, main_exp[i], i);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_main();
    done = 1'b1;
    wait_valid(ok);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || out_idx !== 2'd1) begin
      n_bad++;
      $display("FAIL rstmid_pending got ok=%b idx=%0d required idx=1", ok, out_idx);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async got v=%b busy=%b ov=%b required 0 0 0", out_valid, busy, overrun);
    end
    @(negedge clk);
    done = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    done = 1'b1;
    for (int i = 0; i < NE; i++) begin
      wait_valid(ok);
      n_cmp++;
      if (!ok || out_data !== main_exp[i] || out_idx !== 2'(i)) begin
        n_bad++;
        $display("FAIL rstmid_restart i=%0d got ok=%b d=%h idx=%0d required d=%h idx=%0d",
                 i, ok, out_data, out_idx, main_exp[i], i);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_drain();
    test_stall();
    load(32'h00000801, 32'h00000803, 32'h00000FFF, 32'h00000000, 5'd15, 5'd15, 5'd15, 5'd15);
    test_convert("convert_rne", rnd_exp);
    // -2^31 * 2^(0-25) = -64 -> biased exponent 21 -> 0xD400.
    load(32'h00010000, 32'hFFFF0000, 32'h00000001, 32'h80000000, 5'd30, 5'd30, 5'd0, 5'd0);
    test_convert("convert_sat", sat_exp);
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
